mips_cpu: RTL and testbench

MIPS_CPU -- requirements
Module: mips_cpu

---
 rtl/mips_cpu.sv | 175 +++++++++++++++++
 tb/tb_mips_cpu.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu.sv
// Non-pipelined multicycle MIPS-I subset core on a 16-bit asynchronous SRAM port.
// Define MIPS_CPU_SHIFTER_EN to add SLL/SRL/SRA/SLLV/SRLV/SRAV; otherwise they decode as NOP.
module mips_cpu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [17:0] addr,
    inout  wire  [15:0] data,
    output logic        wre,
    output logic        oute,
    output logic        hb_mask,
    output logic        lb_mask,
    output logic        chip_en
);

    typedef enum logic [2:0] {
        S_FETCH_LO, S_FETCH_HI, S_DECODE, S_EXEC, S_MEM_LO, S_MEM_HI, S_WB
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] regs [32];
    logic [16:0] ea_word;
    logic [31:0] sdata;
    logic [15:0] mdr_lo;
    logic [31:0] res;
    logic [4:0]  dst;
    logic        wen;
    logic        mem_wr;

    // Instruction fields and register read ports
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] rs_val, rt_val, imm_s, imm_z, pc_plus4, eff;
    assign opcode   = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign shamt    = ir[10:6];
    assign funct    = ir[5:0];
    assign rs_val   = regs[rs];
    assign rt_val   = regs[rt];
    assign imm_s    = {{16{ir[15]}}, ir[15:0]};
    assign imm_z    = {16'h0000, ir[15:0]};
    assign pc_plus4 = pc + 32'd4;
    assign eff      = rs_val + imm_s;

    logic unused_bits;
    assign unused_bits = ^{eff[31:19], eff[1:0], shamt};

    // Execute-stage decode: result, destination, next PC and memory op
    logic [31:0] alu_res, next_pc;
    logic [4:0]  wr_dst;
    logic        wr_en, mem_op, mem_st;
    always_comb begin
        alu_res = '0;
        next_pc = pc_plus4;
        wr_dst  = rd;
        wr_en   = 1'b0;
        mem_op  = 1'b0;
        mem_st  = 1'b0;
        case (opcode)
            6'h00: begin
                wr_en = 1'b1;
                case (funct)
                    6'h20, 6'h21: alu_res = rs_val + rt_val;
                    6'h22, 6'h23: alu_res = rs_val - rt_val;
                    6'h24: alu_res = rs_val & rt_val;
                    6'h25: alu_res = rs_val | rt_val;
                    6'h26: alu_res = rs_val ^ rt_val;
                    6'h27: alu_res = ~(rs_val | rt_val);
                    6'h2A: alu_res = {31'b0, $signed(rs_val) < $signed(rt_val)};
                    6'h2B: alu_res = {31'b0, rs_val < rt_val};
`ifdef MIPS_CPU_SHIFTER_EN
                    6'h00: alu_res = rt_val << shamt;
                    6'h02: alu_res = rt_val >> shamt;
                    6'h03: alu_res = 32'($signed(rt_val) >>> shamt);
                    6'h04: alu_res = rt_val << rs_val[4:0];
                    6'h06: alu_res = rt_val >> rs_val[4:0];
                    6'h07: alu_res = 32'($signed(rt_val) >>> rs_val[4:0]);
`endif
                    6'h08: begin
                        next_pc = rs_val;
                        wr_en   = 1'b0;
                    end
                    default: wr_en = 1'b0;
                endcase
            end
            6'h08, 6'h09: begin alu_res = rs_val + imm_s; wr_dst = rt; wr_en = 1'b1; end
            6'h0A: begin alu_res = {31'b0, $signed(rs_val) < $signed(imm_s)}; wr_dst = rt; wr_en = 1'b1; end
            6'h0C: begin alu_res = rs_val & imm_z; wr_dst = rt; wr_en = 1'b1; end
            6'h0D: begin alu_res = rs_val | imm_z; wr_dst = rt; wr_en = 1'b1; end
            6'h0E: begin alu_res = rs_val ^ imm_z; wr_dst = rt; wr_en = 1'b1; end
            6'h0F: begin alu_res = {ir[15:0], 16'h0000}; wr_dst = rt; wr_en = 1'b1; end
            6'h23: begin mem_op = 1'b1; wr_dst = rt; wr_en = 1'b1; end
            6'h2B: begin mem_op = 1'b1; mem_st = 1'b1; end
            6'h04: if (rs_val == rt_val) next_pc = pc_plus4 + {imm_s[29:0], 2'b00};
            6'h05: if (rs_val != rt_val) next_pc = pc_plus4 + {imm_s[29:0], 2'b00};
            6'h02: next_pc = {pc_plus4[31:28], ir[25:0], 2'b00};
            6'h03: begin
                next_pc = {pc_plus4[31:28], ir[25:0], 2'b00};
                alu_res = pc_plus4;
                wr_dst  = 5'd31;
                wr_en   = 1'b1;
            end
            default: ;
        endcase
    end

    // Bus strobes decode straight from state so reset deasserts them at once
    logic fetch_st, mem_st_cyc, rd_cyc, wr_cyc, hi_half;
    assign fetch_st   = (state == S_FETCH_LO) || (state == S_FETCH_HI);
    assign mem_st_cyc = (state == S_MEM_LO) || (state == S_MEM_HI);
    assign rd_cyc     = reset && (fetch_st || (mem_st_cyc && !mem_wr));
    assign wr_cyc     = reset && mem_st_cyc && mem_wr;
    assign hi_half    = (state == S_FETCH_HI) || (state == S_MEM_HI);
    assign addr       = mem_st_cyc ? {ea_word, hi_half} : {pc[18:2], hi_half};
    assign chip_en    = ~(rd_cyc | wr_cyc);
    assign oute       = ~rd_cyc;
    assign wre        = ~wr_cyc;
    assign hb_mask    = chip_en;
    assign lb_mask    = chip_en;
    assign data       = wr_cyc ? (hi_half ? sdata[31:16] : sdata[15:0]) : 16'hzzzz;

    // Control sequencer and architectural state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= S_FETCH_LO;
            pc      <= RESET_PC;
            ir      <= '0;
            ea_word <= '0;
            sdata   <= '0;
            mdr_lo  <= '0;
            res     <= '0;
            dst     <= '0;
            wen     <= 1'b0;
            mem_wr  <= 1'b0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH_LO: begin ir[15:0]  <= data; state <= S_FETCH_HI; end
                S_FETCH_HI: begin ir[31:16] <= data; state <= S_DECODE; end
                S_DECODE:   state <= S_EXEC;
                S_EXEC: begin
                    pc      <= next_pc;
                    res     <= alu_res;
                    dst     <= wr_dst;
                    wen     <= wr_en;
                    ea_word <= eff[18:2];
                    sdata   <= rt_val;
                    mem_wr  <= mem_st;
                    if (mem_op)     state <= S_MEM_LO;
                    else if (wr_en) state <= S_WB;
                    else            state <= S_FETCH_LO;
                end
                S_MEM_LO: begin
                    if (!mem_wr) mdr_lo <= data;
                    state <= S_MEM_HI;
                end
                S_MEM_HI: begin
                    if (!mem_wr) res <= {data, mdr_lo};
                    state <= mem_wr ? S_FETCH_LO : S_WB;
                end
                S_WB: begin
                    if (wen && dst != 5'd0) regs[dst] <= res;
                    state <= S_FETCH_LO;
                end
                default: state <= S_FETCH_LO;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu.sv
// Directed bench for mips_cpu: SRAM model, hand-assembled program, reset and write-abort checks.
`timescale 1ns/100ps
module tb_mips_cpu;

    logic        clock;
    logic        reset;
    logic [17:0] addr;
    wire  [15:0] data;
    logic        wre, oute, hb_mask, lb_mask, chip_en;

    mips_cpu dut (
        .clock(clock), .reset(reset), .addr(addr), .data(data), .wre(wre),
        .oute(oute), .hb_mask(hb_mask), .lb_mask(lb_mask), .chip_en(chip_en)
    );

    always #5 clock = ~clock;

    logic [15:0] mem [0:262143];
    assign data = (!chip_en && !oute) ? mem[addr] : 16'hzzzz;
    always @(posedge clock) if (!chip_en && !wre) mem[addr] <= data;

`ifdef MIPS_CPU_SHIFTER_EN
    localparam bit SHIFT = 1'b1;
`else
    localparam bit SHIFT = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int wr_cycles = 0, bad_wr = 0, n_hw4 = 0, n_hw5 = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Write-cycle monitor: strobes and per-halfword write counts
    always @(negedge clock) begin
        if (reset && !wre) begin
            wr_cycles++;
            if (hb_mask || lb_mask || chip_en || !oute) bad_wr++;
            if (addr == 18'd4) n_hw4++;
            if (addr == 18'd5) n_hw5++;
        end
    end

    function automatic logic [31:0] r_op(input int rs, input int rt, input int rd, input int sh, input int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction
    function automatic logic [31:0] i_op(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction
    function automatic logic [31:0] j_op(input int op, input int tgt);
        return {6'(op), 26'(tgt)};
    endfunction

    task automatic put(input int idx, input logic [31:0] w);
        mem[2*idx]   = w[15:0];
        mem[2*idx+1] = w[31:16];
    endtask

    initial begin
        bit done;
        clock = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        put(0,  i_op(6'h09, 0, 17, 5));
        put(1,  r_op(17, 17, 17, 0, 6'h21));
        put(2,  i_op(6'h09, 0, 1, -1));
        put(3,  r_op(0, 1, 2, 0, 6'h2B));
        put(4,  r_op(0, 17, 3, 2, 6'h00));
        put(5,  r_op(0, 1, 4, 4, 6'h03));
        put(6,  r_op(0, 1, 5, 28, 6'h02));
        put(7,  r_op(2, 17, 15, 0, 6'h04));
        put(8,  i_op(6'h0F, 0, 6, 16'h1234));
        put(9,  i_op(6'h0D, 6, 6, 16'hABCD));
        put(10, i_op(6'h2B, 0, 6, 8));
        put(11, r_op(0, 17, 7, 0, 6'h22));
        put(12, r_op(7, 0, 8, 0, 6'h2A));
        put(13, i_op(6'h0E, 6, 9, 16'hFFFF));
        put(14, r_op(0, 0, 10, 0, 6'h27));
        put(15, i_op(6'h08, 0, 11, 16'h8000));
        put(16, i_op(6'h0C, 11, 12, 16'h8001));
        put(17, i_op(6'h0A, 7, 13, -9));
        put(18, i_op(6'h0B, 0, 14, 5));
        put(19, 32'hFFFF_FFFF);
        put(20, i_op(6'h04, 0, 17, 1));
        put(21, i_op(6'h09, 0, 28, 7));
        put(22, i_op(6'h04, 0, 0, 1));
        put(23, i_op(6'h09, 0, 29, 99));
        put(24, i_op(6'h05, 0, 0, 1));
        put(25, i_op(6'h09, 0, 30, 5));
        put(26, i_op(6'h09, 0, 25, 0));
        put(27, i_op(6'h09, 0, 26, 20));
        put(28, i_op(6'h09, 25, 25, 1));
        put(29, i_op(6'h09, 27, 27, 3));
        put(30, i_op(6'h05, 25, 26, -3));
        put(31, i_op(6'h09, 0, 20, 16'h0100));
        put(32, i_op(6'h09, 0, 21, 1));
        put(33, i_op(6'h09, 0, 22, 21));
        put(34, i_op(6'h2B, 20, 21, 0));
        put(35, i_op(6'h09, 20, 20, 4));
        put(36, i_op(6'h09, 21, 21, 1));
        put(37, i_op(6'h05, 21, 22, -4));
        put(38, i_op(6'h09, 0, 20, 16'h0100));
        put(39, i_op(6'h09, 0, 23, 16'h0150));
        put(40, i_op(6'h23, 20, 24, 0));
        put(41, r_op(18, 24, 18, 0, 6'h21));
        put(42, i_op(6'h09, 20, 20, 4));
        put(43, i_op(6'h05, 20, 23, -4));
        put(44, i_op(6'h2B, 0, 18, 16'h0150));
        put(45, i_op(6'h23, 0, 19, 16'h0150));
        put(46, j_op(6'h03, 49));
        put(47, j_op(6'h02, 47));
        put(48, 32'h0000_0000);
        put(49, i_op(6'h09, 16, 16, 1));
        put(50, r_op(31, 0, 0, 0, 6'h08));

        // Short reset pulse before the first clock edge
        #2 reset = 1'b0;
        #1;
        check("rst_addr",    32'(addr),    32'd0);
        check("rst_strobes", {28'd0, chip_en, wre, oute, hb_mask & lb_mask}, 32'hF);
        #1 reset = 1'b1;
        #0.5;
        check("fetch0_addr", 32'(addr), 32'd0);
        check("fetch0_strb", {29'd0, chip_en, oute, wre}, 32'h1);
        @(negedge clock);
        check("fetch1_addr", 32'(addr), 32'd1);
        check("fetch1_oute", 32'(oute), 32'd0);

        done = 1'b0;
        for (int c = 0; c < 5000 && !done; c++) begin
            @(negedge clock);
            if (!oute && addr == 18'd94) done = 1'b1;
        end
        check("halt_reached", 32'(done), 32'd1);
        repeat (4) @(negedge clock);

        check("r0",  dut.regs[0],  32'h0000_0000);
        check("r17_addu", dut.regs[17], 32'd10);
        check("r1_neg1",  dut.regs[1],  32'hFFFF_FFFF);
        check("r2_sltu",  dut.regs[2],  32'd1);
        check("r3_sll",   dut.regs[3],  SHIFT ? 32'd40 : 32'd0);
        check("r4_sra",   dut.regs[4],  SHIFT ? 32'hFFFF_FFFF : 32'd0);
        check("r5_srl",   dut.regs[5],  SHIFT ? 32'h0000_000F : 32'd0);
        check("r15_sllv", dut.regs[15], SHIFT ? 32'd20 : 32'd0);
        check("r6_lui_ori", dut.regs[6], 32'h1234_ABCD);
        check("r7_sub",   dut.regs[7],  32'hFFFF_FFF6);
        check("r8_slt",   dut.regs[8],  32'd1);
        check("r9_xori",  dut.regs[9],  32'h1234_5432);
        check("r10_nor",  dut.regs[10], 32'hFFFF_FFFF);
        check("r11_addi", dut.regs[11], 32'hFFFF_8000);
        check("r12_andi", dut.regs[12], 32'h0000_8000);
        check("r13_slti", dut.regs[13], 32'd1);
        check("r14_undef", dut.regs[14], 32'd0);
        check("r31_undef_jal", dut.regs[31], 32'd188);
        check("r28_beq_nt", dut.regs[28], 32'd7);
        check("r29_beq_t",  dut.regs[29], 32'd0);
        check("r30_bne_nt", dut.regs[30], 32'd5);
        check("r25_loop",   dut.regs[25], 32'd20);
        check("r27_loop",   dut.regs[27], 32'd60);
        check("r16_jr",     dut.regs[16], 32'd1);
        check("r18_sum",    dut.regs[18], 32'd210);
        check("r19_lw",     dut.regs[19], 32'd210);
        check("hw4",  {16'h0, mem[4]},    32'h0000_ABCD);
        check("hw5",  {16'h0, mem[5]},    32'h0000_1234);
        check("hw80", {16'h0, mem[18'h80]}, 32'd1);
        check("hwA6", {16'h0, mem[18'hA6]}, 32'd20);
        check("hwA8", {16'h0, mem[18'hA8]}, 32'd210);
        check("hwA9", {16'h0, mem[18'hA9]}, 32'd0);
        check("wr_cycles", 32'(wr_cycles), 32'd44);
        check("wr_strobes", 32'(bad_wr), 32'd0);
        check("hw4_writes", 32'(n_hw4), 32'd1);
        check("hw5_writes", 32'(n_hw5), 32'd1);

        // Reset during the low-half write of a store must abort the word
        put(0, i_op(6'h0F, 0, 1, 16'h5555));
        put(1, i_op(6'h0D, 1, 1, 16'h6666));
        put(2, i_op(6'h2B, 0, 1, 16'h0300));
        mem[18'h180] = 16'hDEAD;
        mem[18'h181] = 16'hBEEF;
        @(negedge clock);
        reset = 1'b0;
        #1 reset = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clock);
            if (!wre) done = 1'b1;
        end
        check("abort_seen_write", {31'd0, done}, 32'd1);
        check("abort_wr_addr", 32'(addr), 32'h180);
        #1 reset = 1'b0;
        #0.5;
        check("abort_strobes", {29'd0, chip_en, wre, oute}, 32'h7);
        check("abort_addr", 32'(addr), 32'd0);
        @(posedge clock);
        #1;
        check("abort_hw_lo", {16'h0, mem[18'h180]}, 32'h0000_DEAD);
        check("abort_hw_hi", {16'h0, mem[18'h181]}, 32'h0000_BEEF);
        check("abort_r1", dut.regs[1], 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
